// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StData
    } arb_state_e;

    localparam int unsigned StarveMaxDefault = 4;
    localparam int unsigned AddrW            = 32;
    localparam int unsigned DataW            = 32;
    localparam int unsigned MaskW            = 4;

    localparam logic [MaskW-1:0] FetchMask = '1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one memory port, one access at a time.
// Data wins ties unless fetch has been passed over STARVE_MAX times in a row.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             if_req,
    input  logic [AddrW-1:0] if_addr,
    output logic [DataW-1:0] if_rdata,
    output logic             if_valid,

    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [AddrW-1:0] dm_addr,
    input  logic [DataW-1:0] dm_wdata,
    input  logic [MaskW-1:0] dm_mask,
    output logic [DataW-1:0] dm_rdata,
    output logic             dm_valid,

    output logic             bus_req,
    output logic             bus_we,
    output logic [AddrW-1:0] bus_addr,
    output logic [DataW-1:0] bus_wdata,
    output logic [MaskW-1:0] bus_mask,
    input  logic             bus_ack,
    input  logic [DataW-1:0] bus_rdata,

    output logic             stall_IF,
    output logic             stall_MW
);

    localparam int unsigned     CntW   = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CntW-1:0]  starve_cnt_q, starve_cnt_d;
    logic             bus_we_q, bus_we_d;
    logic [AddrW-1:0] bus_addr_q, bus_addr_d;
    logic [DataW-1:0] bus_wdata_q, bus_wdata_d;
    logic [MaskW-1:0] bus_mask_q, bus_mask_d;
    logic             if_valid_q, if_valid_d;
    logic             dm_valid_q, dm_valid_d;
    logic [DataW-1:0] if_rdata_q, if_rdata_d;
    logic [DataW-1:0] dm_rdata_q, dm_rdata_d;

    logic data_wins;

    // Data is preferred unless fetch is waiting and has hit its starvation limit.
    assign data_wins = dm_req && ((starve_cnt_q < CntMax) || !if_req);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_mask_d   = bus_mask_q;
        if_valid_d   = 1'b0;
        dm_valid_d   = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (data_wins) begin
                    state_d     = StData;
                    bus_we_d    = dm_we;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                    bus_mask_d  = dm_mask;
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CntMax) begin
                        starve_cnt_d = starve_cnt_q + CntW'(1);
                    end
                end else if (if_req) begin
                    state_d      = StFetch;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = if_addr;
                    bus_wdata_d  = '0;
                    bus_mask_d   = FetchMask;
                    starve_cnt_d = '0;
                end
            end
            StFetch: begin
                if (bus_ack) begin
                    state_d    = StIdle;
                    if_valid_d = 1'b1;
                    if_rdata_d = bus_rdata;
                end
            end
            StData: begin
                if (bus_ack) begin
                    state_d    = StIdle;
                    dm_valid_d = 1'b1;
                    // Stores leave the last load result visible.
                    if (!bus_we_q) begin
                        dm_rdata_d = bus_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_mask_q   <= '0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_mask_q   <= bus_mask_d;
            if_valid_q   <= if_valid_d;
            dm_valid_q   <= dm_valid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
        end
    end

    assign bus_req   = (state_q != StIdle);
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_mask  = bus_mask_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_IF  = if_req & ~if_valid_q;
    assign stall_MW  = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus random traffic for mem_arbiter, checked every cycle against a
// transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int unsigned SM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, bus_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, bus_rdata;
    logic [3:0]  dm_mask;
    logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
    logic        if_valid, dm_valid, bus_req, bus_we, stall_IF, stall_MW;
    logic [3:0]  bus_mask;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_mask   (dm_mask),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_mask  (bus_mask),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .stall_IF  (stall_IF),
        .stall_MW  (stall_MW)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: who owns the port, how long it has waited, what was granted.
    int          m_owner;    // 0 none, 1 fetch, 2 data
    int          m_wait;
    int unsigned m_starve;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic        m_we, m_if_valid, m_dm_valid;
    logic [3:0]  m_mask;

    // Stimulus knobs and observations.
    int          ack_delay = 0;
    bit          spur_ack  = 0;
    bit          rand_rdata = 0;
    logic [31:0] fixed_rdata = '0;
    bit          if_hold = 0, dm_hold = 0;
    bit          rand_mode = 0;
    int          cyc = 0;
    logic        prev_bus_req = 1'b0;
    logic [31:0] grants[$];
    int          if_valid_cnt, dm_valid_cnt, bus_req_cnt, stall_if_cnt, last_if_valid_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_owner    = 0;
        m_wait     = 0;
        m_starve   = 0;
        m_addr     = '0;
        m_wdata    = '0;
        m_we       = 1'b0;
        m_mask     = '0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        m_if_valid = 1'b0;
        m_dm_valid = 1'b0;
    endtask

    // Applies one clock edge worth of arbitration rules to the model.
    task automatic m_step();
        logic v_if = 1'b0;
        logic v_dm = 1'b0;
        if (m_owner == 0) begin
            if (dm_req && (m_starve < SM || !if_req)) begin
                m_owner  = 2;
                m_addr   = dm_addr;
                m_we     = dm_we;
                m_wdata  = dm_wdata;
                m_mask   = dm_mask;
                m_starve = if_req ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
            end else if (if_req) begin
                m_owner  = 1;
                m_addr   = if_addr;
                m_we     = 1'b0;
                m_wdata  = '0;
                m_mask   = 4'hF;
                m_starve = 0;
            end
            m_wait = 0;
        end else if (bus_ack) begin
            if (m_owner == 1) begin
                v_if       = 1'b1;
                m_if_rdata = bus_rdata;
            end else begin
                v_dm = 1'b1;
                if (!m_we) m_dm_rdata = bus_rdata;
            end
            m_owner = 0;
        end else begin
            m_wait++;
        end
        m_if_valid = v_if;
        m_dm_valid = v_dm;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".bus_req"},   bus_req,   (m_owner != 0));
        chk({ph, ".bus_we"},    bus_we,    m_we);
        chk({ph, ".bus_addr"},  bus_addr,  m_addr);
        chk({ph, ".bus_wdata"}, bus_wdata, m_wdata);
        chk({ph, ".bus_mask"},  bus_mask,  m_mask);
        chk({ph, ".if_valid"},  if_valid,  m_if_valid);
        chk({ph, ".if_rdata"},  if_rdata,  m_if_rdata);
        chk({ph, ".dm_valid"},  dm_valid,  m_dm_valid);
        chk({ph, ".dm_rdata"},  dm_rdata,  m_dm_rdata);
        chk({ph, ".stall_IF"},  stall_IF,  if_req & ~m_if_valid);
        chk({ph, ".stall_MW"},  stall_MW,  dm_req & ~m_dm_valid);
    endtask

    task automatic clear_obs();
        grants.delete();
        if_valid_cnt = 0;
        dm_valid_cnt = 0;
        bus_req_cnt  = 0;
        stall_if_cnt = 0;
        last_if_valid_cyc = -100;
    endtask

    // One clock: drive the memory side, check, advance the model, take the edge, react.
    task automatic cycle(input string ph);
        bus_ack   = (m_owner != 0) ? (m_wait >= ack_delay) : spur_ack;
        bus_rdata = rand_rdata ? $urandom : fixed_rdata;
        #1;
        check_all(ph);
        if (bus_req && !prev_bus_req) grants.push_back(bus_addr);
        prev_bus_req = bus_req;
        if (bus_req) bus_req_cnt++;
        if (stall_IF) stall_if_cnt++;
        if (if_valid) begin
            if_valid_cnt++;
            last_if_valid_cyc = cyc;
        end
        if (dm_valid) dm_valid_cnt++;
        if (rst) m_reset();
        else m_step();
        @(posedge clk);
        #1;
        cyc++;
        if (m_if_valid) begin
            if (if_hold) if_addr = rand_mode ? $urandom : if_addr;
            else if_req = 1'b0;
        end
        if (m_dm_valid) begin
            if (dm_hold && rand_mode) begin
                dm_addr  = $urandom;
                dm_we    = $urandom_range(0, 1);
                dm_wdata = $urandom;
                dm_mask  = 4'($urandom);
            end else if (!dm_hold) begin
                dm_req = 1'b0;
            end
        end
    endtask

    int t0;

    initial begin
        rst = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; bus_ack = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_mask = '0; bus_rdata = '0;
        m_reset();
        clear_obs();
        #2;
        check_all("reset");
        repeat (2) cycle("reset_hold");
        rst = 1'b0;
        repeat (2) cycle("idle");

        // Lone fetch with zero-wait memory.
        clear_obs();
        ack_delay = 0; fixed_rdata = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h100;
        t0 = cyc;
        repeat (6) cycle("fetch");
        chk("fetch.latency", 32'(last_if_valid_cyc - t0), 32'd2);
        chk("fetch.bus_req_cycles", 32'(bus_req_cnt), 32'd1);
        chk("fetch.rdata", if_rdata, 32'h0050_0093);
        chk("fetch.valid_pulses", 32'(if_valid_cnt), 32'd1);

        // Simultaneous fetch and load: data first, then fetch.
        clear_obs();
        fixed_rdata = 32'h1111_2222;
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_mask = 4'hF; dm_wdata = '0;
        repeat (8) cycle("tie");
        chk("tie.n_grants", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            chk("tie.first_grant", grants[0], 32'h2000);
            chk("tie.second_grant", grants[1], 32'h100);
        end
        chk("tie.stall_IF_cycles", 32'(stall_if_cnt), 32'd4);

        // Continuous loads starve fetch until the limit forces one fetch grant.
        clear_obs();
        fixed_rdata = 32'hCAFE_F00D;
        dm_hold = 1'b1;
        if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        repeat (12) cycle("starve");
        chk("starve.n_grants_ge6", 32'(grants.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < grants.size(); i++)
            chk($sformatf("starve.grant%0d", i), grants[i], (i == 4) ? 32'h100 : 32'h2000);
        dm_hold = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        repeat (4) cycle("drain");

        // Store with a slow memory: bus held steady, dm_rdata keeps the last load.
        clear_obs();
        fixed_rdata = 32'h0BAD_F00D; ack_delay = 3;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'hDEAD_BEEF;
        dm_mask = 4'b0011;
        repeat (8) cycle("store");
        chk("store.bus_req_cycles", 32'(bus_req_cnt), 32'd4);
        chk("store.valid_pulses", 32'(dm_valid_cnt), 32'd1);
        chk("store.rdata_kept", dm_rdata, 32'hCAFE_F00D);

        // Reset mid-access, then spurious acks while idle.
        clear_obs();
        ack_delay = 20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
        repeat (2) cycle("pre_rst");
        chk("pre_rst.busy", bus_req, 1'b1);
        rst = 1'b1;
        #1;
        m_reset();
        check_all("rst_mid");
        dm_req = 1'b0; spur_ack = 1'b1;
        repeat (2) cycle("rst_mid_hold");
        rst = 1'b0;
        clear_obs();
        repeat (4) cycle("spur_ack");
        chk("spur.dm_valid_pulses", 32'(dm_valid_cnt), 32'd0);
        chk("spur.bus_req_cycles", 32'(bus_req_cnt), 32'd0);
        spur_ack = 1'b0;

        // Random traffic.
        rand_mode = 1'b1; rand_rdata = 1'b1;
        for (int n = 0; n < 400; n++) begin
            spur_ack  = ($urandom_range(0, 3) == 0);
            ack_delay = $urandom_range(0, 3);
            if_hold   = ($urandom_range(0, 2) == 0);
            dm_hold   = ($urandom_range(0, 2) == 0);
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req   = 1'b1;
                dm_we    = $urandom_range(0, 1);
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_mask  = 4'($urandom);
            end
            if (m_owner == 1 && $urandom_range(0, 15) == 0) if_req = 1'b0;
            if (m_owner == 2 && $urandom_range(0, 15) == 0) dm_req = 1'b0;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive data grants while fetch waits before fetch wins once.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  fetch stage requests instruction word; held until if_valid.
REQ-005 if_addr  input  32  fetch address (PC); stable while if_req.
REQ-006 if_rdata  output  32  fetched instruction, valid with if_valid.
REQ-007 if_valid  output  1  one-cycle pulse, fetch complete.
REQ-008 dm_req  input  1  MW-stage load/store request; held until dm_valid.
REQ-009 dm_we  input  1  1 = store, 0 = load.
REQ-010 dm_addr  input  32  data address.
REQ-011 dm_wdata  input  32  store data.
REQ-012 dm_mask  input  4  byte enables.
REQ-013 dm_rdata  output  32  load data, valid with dm_valid.
REQ-014 dm_valid  output  1  one-cycle pulse, data access complete.
REQ-015 bus_req, bus_we  output  1 each  shared memory port request / write.
REQ-016 bus_addr, bus_wdata  output  32 each; bus_mask  output  4.
REQ-017 bus_ack  input  1  memory completes current access this cycle.
REQ-018 bus_rdata  input  32  read data, valid with bus_ack.
REQ-019 stall_IF, stall_MW  output  1 each  hold fetch / MW stage.

Function
REQ-020 FSM states IDLE, FETCH, DATA; one access outstanding at a time.
REQ-021 IDLE: dm_req and (starve_cnt < STARVE_MAX or !if_req) -> DATA; else if_req -> FETCH; else stay IDLE.
REQ-022 On grant edge, bus_addr/bus_we/bus_wdata/bus_mask latched from winner (fetch: we=0, mask=4'hF, wdata=0); held stable until ack.
REQ-023 bus_req = 1 exactly in FETCH/DATA, i.e. from cycle after grant through ack cycle inclusive.
REQ-024 bus_ack in FETCH/DATA -> IDLE next cycle; if_rdata/dm_rdata registered from bus_rdata; matching valid pulses 1 cycle after ack.
REQ-025 Minimum latency with bus_ack same cycle as bus_req: request -> valid = 2 cycles; back-to-back grants separated by one IDLE cycle.
REQ-026 bus_ack in IDLE ignored; no valid pulse, no state change.
REQ-027 Store: dm_rdata unchanged (holds previous value); dm_valid still pulses.
REQ-028 starve_cnt (width clog2(STARVE_MAX+1)): +1 on each DATA grant with if_req high, saturates at STARVE_MAX; cleared on FETCH grant or on DATA grant with if_req low.
REQ-029 Simultaneous if_req and dm_req in IDLE: data wins unless starve_cnt == STARVE_MAX.
REQ-030 stall_IF = if_req & !if_valid; stall_MW = dm_req & !dm_valid; combinational.
REQ-031 Requester dropping req mid-access: access still completes; valid pulse still issued.

Reset
REQ-032 rst asserted: state IDLE, starve_cnt 0, bus_req/bus_we 0, bus_addr/bus_wdata 0, bus_mask 0, if_valid/dm_valid 0, if_rdata/dm_rdata 0, immediately (asynchronous).
REQ-033 Reset mid-access abandons transaction; no valid pulse after release; first post-reset grant no earlier than first clk edge with rst low.

Structure
REQ-034 Package mem_arb_pkg: state enum (IDLE, FETCH, DATA), STARVE_MAX default, bus width constants.
REQ-035 Single flat module; no sub-module required.

Verification
REQ-036 Fetch only, ack same cycle as bus_req, if_addr=0x100, bus_rdata=0x00500093 -> bus_req 1 cycle, if_rdata=0x00500093, if_valid 2 cycles after req, stall_IF high until valid.
REQ-037 Simultaneous if_req/dm_req (load 0x2000), ack 1 cycle -> DATA granted first, then FETCH; stall_IF held through both accesses.
REQ-038 STARVE_MAX=4, dm_req held with continuous loads, if_req held -> 4 data grants, 5th grant FETCH, starve_cnt back to 0.
REQ-039 Store dm_addr=0x3000, dm_wdata=0xDEADBEEF, dm_mask=4'b0011, ack delayed 3 cycles -> bus signals stable 4 cycles, dm_valid one pulse, dm_rdata unchanged.
REQ-040 rst asserted during DATA before ack -> bus_req low same cycle, no dm_valid, all outputs at REQ-032 values; spurious bus_ack in IDLE ignored.
